// File: rtl/usart_pkg.sv
// ---------------------------------------------------------------------------
// usart_pkg : shared USART constants and the receiver state encoding
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package usart_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  localparam int          USART_DATA_BITS = 8;
  localparam logic [11:0] USART_MIN_CPB   = 12'd2;

  // Below two cycles per bit there is no usable mid-bit sample point.
  function automatic logic cpb_valid(input logic [11:0] cpb);
    return cpb >= USART_MIN_CPB;
  endfunction

endpackage

`default_nettype wire

// File: rtl/usart_sync.sv
// ---------------------------------------------------------------------------
// usart_sync : flop-chain synchronizer for asynchronous pad inputs, resets high
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/usart_rx.sv
// ---------------------------------------------------------------------------
// usart_rx : 8N1 serial receiver with one-byte holding register and error flags
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usart_rx
  import usart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        comm_clock,
  input  logic        reset_n,
  input  logic [11:0] clocks_per_bit,
  input  logic        rx_pin,
  output logic [7:0]  data_out,
  output logic        valid,
  input  logic        ready,
  output logic        framing_error,
  output logic        overrun,
  output logic        busy
);

  logic        rx_s;
  logic [2:0]  state_q, state_d;
  logic [11:0] cyc_q, cyc_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        deliver;
  logic [11:0] half_m1;
  logic [11:0] cpb_m1;
  logic        handshake;

  usart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (comm_clock),
    .rst_ni (reset_n),
    .d_i    (rx_pin),
    .q_o    (rx_s)
  );

  assign half_m1   = {1'b0, clocks_per_bit[11:1]} - 12'd1;
  assign cpb_m1    = clocks_per_bit - 12'd1;
  assign handshake = valid_q && ready;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 12'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cyc_q == half_m1) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc_q == cpb_m1) begin
          cyc_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(USART_DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (cyc_q == cpb_m1) begin
          cyc_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cyc_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cyc_d   = '0;
        state_d = IDLE;
      end
    endcase
    // An unusable divisor parks the receiver and silently drops any frame in flight.
    if (!cpb_valid(clocks_per_bit)) begin
      state_d = IDLE;
      cyc_d   = '0;
      deliver = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (handshake) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || handshake) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out      = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_usart_rx.sv
// ---------------------------------------------------------------------------
// tb_usart_rx : self-checking bench for usart_rx with a byte scoreboard
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_usart_rx;

  logic        comm_clock = 1'b0;
  logic        reset_n;
  logic [11:0] clocks_per_bit;
  logic        rx_pin;
  logic [7:0]  data_out;
  logic        valid;
  logic        ready;
  logic        framing_error;
  logic        overrun;
  logic        busy;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         valid_cnt = 0;
  int         fe_cnt    = 0;
  int         busy_cnt  = 0;

  usart_rx #(.SYNC_STAGES(2)) dut (
    .comm_clock     (comm_clock),
    .reset_n        (reset_n),
    .clocks_per_bit (clocks_per_bit),
    .rx_pin         (rx_pin),
    .data_out       (data_out),
    .valid          (valid),
    .ready          (ready),
    .framing_error  (framing_error),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #5 comm_clock = ~comm_clock;

  // Inputs change on negedges; sampling just before the next rising edge sees what the DUT sees.
  initial begin
    forever begin
      @(posedge comm_clock);
      #8;
      if (reset_n === 1'b1) begin
        if (valid)         valid_cnt++;
        if (framing_error) fe_cnt++;
        if (busy)          busy_cnt++;
        if (valid && ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected data_out=%h expected=none", data_out);
          end else begin
            mon_exp = exp_q.pop_front();
            if (data_out !== mon_exp) begin
              failures++;
              $display("FAIL pop_data data_out=%h expected=%h", data_out, mon_exp);
            end
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int bitlen, input int stoplen);
    rx_pin = 1'b0;
    repeat (bitlen) @(negedge comm_clock);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (bitlen) @(negedge comm_clock);
    end
    rx_pin = stop_bit;
    repeat (stoplen) @(negedge comm_clock);
    rx_pin = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; rx_pin = 1'b1; ready = 1'b0; clocks_per_bit = 12'd16;
    repeat (3) @(negedge comm_clock);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
    checks++; if (framing_error !== 1'b0) begin failures++; $display("FAIL reset_fe got=%b exp=0", framing_error); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    repeat (2) @(negedge comm_clock);
  endtask

  task automatic test_nominal;
    int v0, f0;
    clocks_per_bit = 12'd16; ready = 1'b1;
    v0 = valid_cnt; f0 = fe_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 16, 16);
    repeat (4) @(negedge comm_clock);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL nominal_delivered pending=%0d exp=0", exp_q.size()); end
    checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL nominal_valid_cycles got=%0d exp=1", valid_cnt - v0); end
    checks++; if (fe_cnt != f0) begin failures++; $display("FAIL nominal_fe got=%0d exp=0", fe_cnt - f0); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL nominal_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_glitch;
    int v0, f0, b0;
    clocks_per_bit = 12'd16; ready = 1'b1;
    v0 = valid_cnt; f0 = fe_cnt; b0 = busy_cnt;
    rx_pin = 1'b0;
    repeat (4) @(negedge comm_clock);
    rx_pin = 1'b1;
    repeat (10) @(negedge comm_clock);
    checks++; if (busy_cnt == b0) begin failures++; $display("FAIL glitch_started busy_cycles=%0d exp>0", busy_cnt - b0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy); end
    checks++; if (valid_cnt != v0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (fe_cnt != f0) begin failures++; $display("FAIL glitch_fe got=%0d exp=0", fe_cnt - f0); end
  endtask

  task automatic test_framing;
    int v0, f0, n;
    clocks_per_bit = 12'd8; ready = 1'b1;
    v0 = valid_cnt; f0 = fe_cnt;
    rx_pin = 1'b0;
    repeat (8) @(negedge comm_clock);
    for (int i = 0; i < 8; i++) begin
      rx_pin = (8'h3C >> i) & 8'h01;
      repeat (8) @(negedge comm_clock);
    end
    rx_pin = 1'b0;
    repeat (40) @(negedge comm_clock);
    checks++; if (fe_cnt - f0 != 1) begin failures++; $display("FAIL framing_pulses got=%0d exp=1", fe_cnt - f0); end
    checks++; if (valid_cnt != v0) begin failures++; $display("FAIL framing_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL framing_busy_held got=%b exp=1", busy); end
    rx_pin = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge comm_clock);
      n++;
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL framing_busy_release got=%b exp=0", busy); end
  endtask

  task automatic test_overrun;
    clocks_per_bit = 12'd16; ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 16, 16);
    send_frame(8'h22, 1'b1, 16, 16);
    repeat (2) @(negedge comm_clock);
    checks++; if (data_out !== 8'h11) begin failures++; $display("FAIL overrun_data got=%h exp=11", data_out); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL overrun_valid got=%b exp=1", valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
    ready = 1'b1;
    @(negedge comm_clock);
    ready = 1'b0;
    @(negedge comm_clock);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL overrun_pop_valid got=%b exp=0", valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_back_to_back;
    clocks_per_bit = 12'd4; ready = 1'b0;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
    send_frame(8'hC3, 1'b1, 4, 4);
    // Stop sample lands SYNC_STAGES + half + 9*cpb = 40 rising edges after the start bit is driven.
    fork
      send_frame(8'h5A, 1'b1, 4, 4);
      begin
        repeat (40) @(negedge comm_clock);
        ready = 1'b1;
        @(negedge comm_clock);
        ready = 1'b0;
      end
    join
    @(negedge comm_clock);
    checks++; if (data_out !== 8'h5A) begin failures++; $display("FAIL b2b_data got=%h exp=5a", data_out); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    ready = 1'b1;
    @(negedge comm_clock);
    ready = 1'b0;
    @(negedge comm_clock);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain pending=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_disable;
    int v0, b0;
    clocks_per_bit = 12'd16; ready = 1'b0;
    send_frame(8'h77, 1'b1, 16, 16);
    rx_pin = 1'b0;
    repeat (16 + 3 * 16) @(negedge comm_clock);
    checks++; if (valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL pre_reset valid=%b busy=%b exp=1,1", valid, busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", valid); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL async_reset_data got=%h exp=00", data_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0 || framing_error !== 1'b0) begin failures++; $display("FAIL async_reset_flags ovr=%b fe=%b exp=0,0", overrun, framing_error); end
    rx_pin = 1'b1;
    clocks_per_bit = 12'd1;
    repeat (2) @(negedge comm_clock);
    reset_n = 1'b1;
    v0 = valid_cnt; b0 = busy_cnt;
    send_frame(8'h96, 1'b1, 16, 16);
    repeat (5) @(negedge comm_clock);
    checks++; if (busy_cnt != b0) begin failures++; $display("FAIL disabled_busy got=%0d exp=0", busy_cnt - b0); end
    checks++; if (valid_cnt != v0) begin failures++; $display("FAIL disabled_valid got=%0d exp=0", valid_cnt - v0); end
  endtask

  initial begin
    reset_n = 1'b0; rx_pin = 1'b1; ready = 1'b0; clocks_per_bit = 12'd16;
    @(negedge comm_clock);
    test_reset();
    test_nominal();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_disable();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
